if_id_stall_ctrl: RTL and testbench
===================================

# if_id_stall_ctrl

- Fetch-side responder to the load-use stall request and to EX-stage branch redirects.
- Owns the program counter and the IF/ID pipeline register.
- Applies stall (hold PC and IF/ID, bubble into ID/EX) and flush (redirect PC, squash IF/ID and ID).
- Provides a debug halt handshake that drains the pipeline before acknowledging.
- Sits between the instruction memory (asynchronous read) and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DRAIN_CYCLES, 3: bubble cycles issued after fetch stops, before halt is acknowledged (ID, EX, MEM drain).
- MAX_STALL, 15: consecutive stall cycles tolerated before the watchdog trips.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall_req  in  1  load-use stall request from the hazard detection unit.
- branch_taken  in  1  EX-stage taken branch/jump.
- branch_target  in  32  redirect address, valid with branch_taken.
- imem_instr  in  32  instruction at imem_addr, same cycle.
- halt_req  in  1  level debug halt request.
- imem_addr  out  32  current PC.
- if_id_pc  out  32  PC of the instruction in ID.
- if_id_instr  out  32  instruction in ID.
- if_id_valid  out  1  ID holds a real instruction.
- id_ex_bubble  out  1  ID/EX must load zeroed control this cycle (combinational).
- halt_ack  out  1  pipeline drained and fetch frozen.
- stall_timeout  out  1  sticky watchdog error.

## Operation
- NOP = 32'h0000_0013 (addi x0,x0,0).
- Reset values:
  - pc = RESET_PC
  - if_id_pc = 0
  - if_id_instr = NOP
  - if_id_valid = 0
  - state = RUN
  - drain counter = 0
  - stall counter = 0
  - stall_timeout = 0
  - halt_ack = 0
- FSM states: RUN, DRAIN, HALTED.
- RUN, per-cycle priority:
  1. branch_taken: pc <= branch_target; IF/ID <= {0, NOP, 0}; id_ex_bubble = 1.
  2. stall_req: pc, IF/ID hold; id_ex_bubble = 1.
  3. else: IF/ID <= {pc, imem_instr, 1}; pc <= pc + 4 (mod 2^32, wraps silently).
- RUN -> DRAIN when halt_req = 1 and no branch_taken and no stall_req this cycle.
  - That cycle's fetch is still captured.
- DRAIN:
  - pc holds; IF/ID loads NOP/invalid each cycle.
  - branch_taken still redirects pc and squashes, but the state stays DRAIN.
  - stall_req is honoured (hold, bubble) and does not advance the counter.
  - The counter increments on non-stalled cycles.
  - Go to HALTED when the counter reaches DRAIN_CYCLES.
- HALTED:
  - halt_ack = 1 (registered); pc and IF/ID frozen; id_ex_bubble = 1.
  - halt_req = 0 -> RUN next cycle; halt_ack clears in the same edge; the counter clears.
- halt_req dropped during DRAIN -> RUN next cycle; halt_ack never asserts.
- Watchdog:
  - The stall counter counts consecutive stall_req cycles, saturating at MAX_STALL+1.
  - Any cycle without stall_req clears it.
  - stall_timeout sets when the counter reaches MAX_STALL+1 and is cleared only by reset.
- Reset asserted mid-operation (any state) returns every register to its reset value immediately.

## Timing
- Redirect: branch_taken in cycle N -> imem_addr = branch_target in N+1; the target instruction is in ID in N+2.
- Stall: stall_req in N -> imem_addr and IF/ID in N+1 equal their N values; id_ex_bubble is high in N (same cycle, no register).
- Halt latency from halt_req rising with clean RUN = 1 + DRAIN_CYCLES + stall cycles during drain; halt_ack is high from that edge.
- halt_req sampled each edge; no ack/req overlap requirement beyond the level protocol.

## Configuration
- IF_ID_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_stall_cycles and perf_flush_count.
  - perf_stall_cycles counts stall_req cycles in RUN and DRAIN.
  - perf_flush_count counts branch_taken cycles.
  - Both reset to 0 and wrap at 2^32.
- IF_ID_PERF_CNT_EN not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared pipeline package: NOP_INSTR constant, XLEN = 32, fetch FSM state enum (RUN/DRAIN/HALTED).
- One natural sub-module, stall_watchdog: saturating counter plus sticky flag, parameterised by MAX_STALL.
- The IF/ID register stays inline.

## Test plan
- Reset with RESET_PC = 32'h100 → imem_addr = 0x100, if_id_valid = 0, if_id_instr = 0x13, halt_ack = 0, stall_timeout = 0.
- Free run 4 cycles, then stall_req for 2 cycles → imem_addr holds 0x110 and if_id_pc holds 0x10C through both cycles, id_ex_bubble = 1 both cycles, and fetch resumes at 0x110 after.
- branch_taken with target 0x200 coincident with stall_req → id_ex_bubble = 1, next imem_addr = 0x200, if_id_valid = 0, and 0x200 is in ID two cycles later.
- halt_req held from RUN with DRAIN_CYCLES = 3 and one stall inside DRAIN → halt_ack rises exactly 5 edges after the request edge; dropping halt_req clears halt_ack next edge and fetch resumes at the held pc.
- stall_req held 16 cycles with MAX_STALL = 15 → stall_timeout rises on the 16th edge and stays high after stall_req drops until reset.
- With IF_ID_PERF_CNT_EN defined, 3 stalls and 2 branches → perf_stall_cycles = 3, perf_flush_count = 2; assert reset mid-count → both 0.

Source files
------------

// File: rtl/if_id_stall_ctrl_pkg.sv
// Shared fetch-stage definitions: data width, the canonical NOP and the fetch FSM states.
package if_id_stall_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    // Sequential fetch address; wraps silently at 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_stall_ctrl_stall_watchdog.sv
// Consecutive-stall watchdog: saturating run-length counter plus a sticky timeout flag
// that only reset clears.
module if_id_stall_ctrl_stall_watchdog #(
    parameter int unsigned MAX_STALL = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int unsigned Limit = MAX_STALL + 1;
    localparam int unsigned CntW  = $clog2(Limit + 1);
    localparam logic [CntW-1:0] LimitC = CntW'(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // Count consecutive stall cycles, saturate at the limit, flag once the limit is reached.
    always_comb begin
        cnt_d = '0;
        if (stall_i) begin
            cnt_d = (cnt_q == LimitC) ? cnt_q : cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (cnt_d == LimitC);
    end

    // Watchdog state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// Fetch-side stall/flush controller: owns the PC and the IF/ID register, applies load-use
// stalls and EX redirects, and drains the pipeline for a debug halt handshake.
// Optional feature macro: IF_ID_PERF_CNT_EN adds stall-cycle and flush performance counters.
module if_id_stall_ctrl
    import if_id_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MAX_STALL    = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_req,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            halt_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            id_ex_bubble,
    output logic            halt_ack,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count,
`endif
    output logic            stall_timeout
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DrainW-1:0] DrainDone = DrainW'(DRAIN_CYCLES);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              ack_q, ack_d;
    logic              bubble;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
`endif

    // Next-state for PC, IF/ID, drain FSM and the combinational ID/EX bubble.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        drain_d      = drain_q;
        ack_d        = ack_q;
        bubble       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    pc_d         = branch_target;
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    bubble       = 1'b1;
                end else if (stall_req) begin
                    bubble = 1'b1;
                end else begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_instr;
                    ifid_valid_d = 1'b1;
                    pc_d         = next_pc(pc_q);
                    // The halt only takes effect on a clean fetch cycle; this fetch still lands.
                    if (halt_req) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end

            StDrain: begin
                // Fetch is stopped: only redirects move the PC, IF/ID fills with bubbles.
                if (branch_taken) begin
                    pc_d         = branch_target;
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    bubble       = 1'b1;
                end else if (stall_req) begin
                    bubble = 1'b1;
                end else begin
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end

                if (!halt_req) begin
                    state_d = StRun;
                    drain_d = '0;
                end else if (drain_q == DrainDone) begin
                    state_d = StHalted;
                    ack_d   = 1'b1;
                end else if (!stall_req) begin
                    drain_d = drain_q + 1'b1;
                end
            end

            StHalted: begin
                bubble = 1'b1;
                if (!halt_req) begin
                    state_d = StRun;
                    ack_d   = 1'b0;
                    drain_d = '0;
                end
            end

            default: begin
                state_d = StRun;
                ack_d   = 1'b0;
                drain_d = '0;
            end
        endcase
    end

`ifdef IF_ID_PERF_CNT_EN
    // Performance counters: stalls seen while fetching or draining, and every redirect.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_req && (state_q != StHalted)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (branch_taken) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end
`endif

    // All fetch-side state, including FSM and registered halt_ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            drain_q      <= '0;
            ack_q        <= 1'b0;
`ifdef IF_ID_PERF_CNT_EN
            perf_stall_q <= '0;
            perf_flush_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            drain_q      <= drain_d;
            ack_q        <= ack_d;
`ifdef IF_ID_PERF_CNT_EN
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
`endif
        end
    end

    if_id_stall_ctrl_stall_watchdog #(
        .MAX_STALL(MAX_STALL)
    ) u_stall_watchdog (
        .clk      (clk),
        .reset    (reset),
        .stall_i  (stall_req),
        .timeout_o(stall_timeout)
    );

    assign imem_addr    = pc_q;
    assign if_id_pc     = ifid_pc_q;
    assign if_id_instr  = ifid_instr_q;
    assign if_id_valid  = ifid_valid_q;
    assign id_ex_bubble = bubble;
    assign halt_ack     = ack_q;

`ifdef IF_ID_PERF_CNT_EN
    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed bench for if_id_stall_ctrl: reset, stall, redirect, halt drain, watchdog and
// (when IF_ID_PERF_CNT_EN is defined) the performance counters.
module tb_if_id_stall_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic        halt_ack;
    logic        stall_timeout;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    int checks = 0;
    int errors = 0;

    if_id_stall_ctrl #(
        .RESET_PC    (32'h0000_0100),
        .DRAIN_CYCLES(3),
        .MAX_STALL   (15)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_req        (stall_req),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_instr       (imem_instr),
        .halt_req         (halt_req),
        .imem_addr        (imem_addr),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr),
        .if_id_valid      (if_id_valid),
        .id_ex_bubble     (id_ex_bubble),
        .halt_ack         (halt_ack),
`ifdef IF_ID_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count),
`endif
        .stall_timeout    (stall_timeout)
    );

    // Asynchronous instruction memory: each word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall_req = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        halt_req = 1'b0;
        step();
        step();
        checks++; if (imem_addr !== 32'h100) begin errors++;
            $display("FAIL reset_pc got %h want %h", imem_addr, 32'h100); end
        checks++; if (if_id_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h13) begin errors++;
            $display("FAIL reset_instr got %h want 00000013", if_id_instr); end
        checks++; if (if_id_pc !== 32'h0) begin errors++;
            $display("FAIL reset_ifid_pc got %h want 0", if_id_pc); end
        checks++; if (halt_ack !== 1'b0 || stall_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_flags got ack=%b to=%b want 0 0", halt_ack, stall_timeout); end
        reset = 1'b0;
    endtask

    // Four clean fetches, then a two-cycle stall, then resume.
    task automatic test_stall();
        for (int i = 0; i < 4; i++) step();
        checks++; if (imem_addr !== 32'h110 || if_id_pc !== 32'h10C) begin errors++;
            $display("FAIL run4 got pc=%h idpc=%h want 110 10c", imem_addr, if_id_pc); end
        checks++; if (if_id_instr !== mem_word(32'h10C) || if_id_valid !== 1'b1) begin errors++;
            $display("FAIL run4_instr got %h v=%b want %h v=1", if_id_instr, if_id_valid,
                     mem_word(32'h10C)); end
        stall_req = 1'b1;
        #1;
        checks++; if (id_ex_bubble !== 1'b1) begin errors++;
            $display("FAIL stall_bubble0 got %b want 1", id_ex_bubble); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_addr !== 32'h110 || if_id_pc !== 32'h10C) begin errors++;
                $display("FAIL stall_hold%0d got pc=%h idpc=%h want 110 10c", i, imem_addr,
                         if_id_pc); end
            if (i == 0) begin
                checks++; if (id_ex_bubble !== 1'b1) begin errors++;
                    $display("FAIL stall_bubble1 got %b want 1", id_ex_bubble); end
            end
        end
        stall_req = 1'b0;
        #1;
        checks++; if (id_ex_bubble !== 1'b0) begin errors++;
            $display("FAIL nostall_bubble got %b want 0", id_ex_bubble); end
        step();
        checks++; if (if_id_pc !== 32'h110 || imem_addr !== 32'h114) begin errors++;
            $display("FAIL resume got idpc=%h pc=%h want 110 114", if_id_pc, imem_addr); end
    endtask

    // Redirect coincident with a stall: the branch wins.
    task automatic test_branch();
        branch_taken = 1'b1;
        branch_target = 32'h200;
        stall_req = 1'b1;
        #1;
        checks++; if (id_ex_bubble !== 1'b1) begin errors++;
            $display("FAIL br_bubble got %b want 1", id_ex_bubble); end
        step();
        branch_taken = 1'b0;
        stall_req = 1'b0;
        checks++; if (imem_addr !== 32'h200) begin errors++;
            $display("FAIL br_pc got %h want 200", imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin errors++;
            $display("FAIL br_squash got v=%b instr=%h want 0 00000013", if_id_valid,
                     if_id_instr); end
        step();
        checks++; if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1 ||
                      if_id_instr !== mem_word(32'h200)) begin errors++;
            $display("FAIL br_target_id got pc=%h v=%b instr=%h want 200 1 %h", if_id_pc,
                     if_id_valid, if_id_instr, mem_word(32'h200)); end
    endtask

    // Halt with one stall inside the drain: ack 5 edges after the request edge.
    task automatic test_halt();
        halt_req = 1'b1;
        step();
        checks++; if (if_id_pc !== 32'h204 || imem_addr !== 32'h208 || halt_ack !== 1'b0) begin
            errors++;
            $display("FAIL halt_req_edge got idpc=%h pc=%h ack=%b want 204 208 0", if_id_pc,
                     imem_addr, halt_ack); end
        stall_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            stall_req = 1'b0;
            checks++; if (halt_ack !== 1'b0) begin errors++;
                $display("FAIL halt_early edge%0d got ack=%b want 0", i, halt_ack); end
        end
        step();
        checks++; if (halt_ack !== 1'b1) begin errors++;
            $display("FAIL halt_ack got %b want 1", halt_ack); end
        checks++; if (imem_addr !== 32'h208 || if_id_valid !== 1'b0 || id_ex_bubble !== 1'b1)
        begin errors++;
            $display("FAIL halted_state got pc=%h v=%b bub=%b want 208 0 1", imem_addr,
                     if_id_valid, id_ex_bubble); end
        halt_req = 1'b0;
        step();
        checks++; if (halt_ack !== 1'b0 || imem_addr !== 32'h208) begin errors++;
            $display("FAIL unhalt got ack=%b pc=%h want 0 208", halt_ack, imem_addr); end
        step();
        checks++; if (if_id_pc !== 32'h208 || imem_addr !== 32'h20C || if_id_valid !== 1'b1)
        begin errors++;
            $display("FAIL refetch got idpc=%h pc=%h v=%b want 208 20c 1", if_id_pc,
                     imem_addr, if_id_valid); end
    endtask

    // 16 consecutive stalls trip the sticky watchdog; only reset clears it.
    task automatic test_watchdog();
        stall_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++; if (stall_timeout !== 1'b0) begin errors++;
                $display("FAIL wd_early edge%0d got %b want 0", i, stall_timeout); end
        end
        step();
        checks++; if (stall_timeout !== 1'b1) begin errors++;
            $display("FAIL wd_trip got %b want 1", stall_timeout); end
        stall_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (stall_timeout !== 1'b1) begin errors++;
            $display("FAIL wd_sticky got %b want 1", stall_timeout); end
        reset = 1'b1;
        #1;
        checks++; if (stall_timeout !== 1'b0 || imem_addr !== 32'h100) begin errors++;
            $display("FAIL wd_reset got to=%b pc=%h want 0 100", stall_timeout, imem_addr); end
        step();
        reset = 1'b0;
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_perf();
        for (int i = 0; i < 3; i++) begin
            stall_req = 1'b1;
            step();
            stall_req = 1'b0;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            branch_taken = 1'b1;
            branch_target = 32'h300;
            step();
            branch_taken = 1'b0;
            step();
        end
        checks++; if (perf_stall_cycles !== 32'd3 || perf_flush_count !== 32'd2) begin errors++;
            $display("FAIL perf_counts got %0d %0d want 3 2", perf_stall_cycles,
                     perf_flush_count); end
        reset = 1'b1;
        #1;
        checks++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin errors++;
            $display("FAIL perf_reset got %0d %0d want 0 0", perf_stall_cycles,
                     perf_flush_count); end
        step();
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_halt();
        test_watchdog();
`ifdef IF_ID_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
